// File: rtl/seg_scan_decoder_if.sv
// Seven-segment scan bus: sampled segment/enable lines plus the decoded frame.
// master drives the lines, slave is the decoder.
interface seg_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   an_in;
  logic [4*DIGITS-1:0] bcd_out;
  logic                frame_valid;
  logic                frame_err;
  logic                stale;

  modport master (
    output seg_in, an_in,
    input  bcd_out, frame_valid, frame_err, stale
  );

  modport slave (
    input  seg_in, an_in,
    output bcd_out, frame_valid, frame_err, stale
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Multiplexed seven-segment receive decoder: debounce, decode, frame assembly.
// Optional frame watchdog enabled by SEG_SCAN_DECODER_TIMEOUT_EN.
module seg_scan_decoder #(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  seg_scan_decoder_if.slave bus
);

  localparam int SW = 7 + DIGITS;
  localparam logic [7:0] STB    = 8'(STABLE_CYCLES);
  localparam logic [7:0] STB_M1 = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]       smp_q, smp_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                fv_q, fv_d;
  logic                ferr_q, ferr_d;

  logic              same;
  logic              cap;
  logic              commit;
  logic [DIGITS-1:0] an_low;
  logic [4:0]        dec;

  // Returns {illegal, nibble}
  function automatic logic [4:0] dec7(input logic [6:0] s);
    unique case (s)
      7'b1000000: dec7 = 5'h00;
      7'b1111001: dec7 = 5'h01;
      7'b0100100: dec7 = 5'h02;
      7'b0110000: dec7 = 5'h03;
      7'b0011001: dec7 = 5'h04;
      7'b0010010: dec7 = 5'h05;
      7'b0000010: dec7 = 5'h06;
      7'b1111000: dec7 = 5'h07;
      7'b0000000: dec7 = 5'h08;
      7'b0010000: dec7 = 5'h09;
      default:    dec7 = 5'h1F;
    endcase
  endfunction

  always_comb begin
    smp_d    = {bus.seg_in, bus.an_in};
    same     = (smp_d == smp_q);
    cnt_d    = 8'd0;
    if (same) begin
      cnt_d = (cnt_q == STB) ? cnt_q : cnt_q + 8'd1;
    end
    an_low   = ~smp_q[DIGITS-1:0];
    // One-shot: the counter passes STB-1 only once per stable run
    cap      = (cnt_d == STB_M1) && $onehot(an_low);
    commit   = &mask_q;
    dec      = dec7(smp_q[SW-1:DIGITS]);

    shadow_d = shadow_q;
    err_d    = err_q;
    mask_d   = mask_q;
    bcd_d    = bcd_q;
    ferr_d   = ferr_q;
    fv_d     = 1'b0;

    for (int k = 0; k < DIGITS; k++) begin
      if (cap && an_low[k]) begin
        shadow_d[4*k +: 4] = dec[3:0];
        err_d[k]           = dec[4];
        mask_d[k]          = 1'b1;
      end
    end

    if (commit) begin
      bcd_d  = shadow_q;
      ferr_d = |err_q;
      fv_d   = 1'b1;
      mask_d = '0;
      err_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      err_q    <= '0;
      shadow_q <= '0;
      bcd_q    <= '0;
      fv_q     <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      smp_q    <= smp_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      bcd_q    <= bcd_d;
      fv_q     <= fv_d;
      ferr_q   <= ferr_d;
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = ferr_q;

`ifdef SEG_SCAN_DECODER_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        stale_q, stale_d;

  always_comb begin
    wd_d    = stale_q ? wd_q : wd_q + 32'd1;
    stale_d = stale_q || (wd_d >= 32'(TIMEOUT_CYCLES));
    if (commit) begin
      wd_d    = '0;
      stale_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q    <= '0;
      stale_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      stale_q <= stale_d;
    end
  end

  assign bus.stale = stale_q;
`else
  wire unused_timeout = (TIMEOUT_CYCLES == 0);
  assign bus.stale = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed table, reset sequence,
// and random scans against a run-length based reference model.
module tb_seg_scan_decoder;

  localparam int ND  = 4;
  localparam int STB = 4;
  localparam int TO  = 50;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seg_scan_decoder_if #(.DIGITS(ND)) bus ();

  seg_scan_decoder #(
    .DIGITS(ND),
    .STABLE_CYCLES(STB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  logic [6:0] gly [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                           7'b0110000, 7'b0011001, 7'b0010010,
                           7'b0000010, 7'b1111000, 7'b0000000,
                           7'b0010000};

  function automatic int glyph_val(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (gly[i] == s) return i;
    return -1;
  endfunction

  // Reference model: counts consecutive identical samples as a plain integer
  logic [10:0] m_last;
  int          m_run;
  logic [3:0]  m_sh [ND];
  bit          m_er [ND];
  bit          m_mk [ND];
  bit          m_pend;
  logic [15:0] m_bcd;
  bit          m_ferr, m_fv, m_stale;
  int          m_wd;

  task automatic model_reset();
    m_last = '0; m_run = 1; m_pend = 0;
    m_bcd = '0; m_ferr = 0; m_fv = 0; m_stale = 0; m_wd = 0;
    for (int i = 0; i < ND; i++) begin
      m_sh[i] = '0; m_er[i] = 0; m_mk[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [6:0] seg, input logic [3:0] an);
    logic [10:0] cur;
    logic [3:0]  low;
    int          v, k, full;
    m_fv = 0;
    if (m_pend) begin
      m_bcd  = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
      m_ferr = m_er[0] | m_er[1] | m_er[2] | m_er[3];
      m_fv   = 1; m_pend = 0;
      for (int i = 0; i < ND; i++) begin m_mk[i] = 0; m_er[i] = 0; end
    end
`ifdef SEG_SCAN_DECODER_TIMEOUT_EN
    if (m_fv) begin m_wd = 0; m_stale = 0; end
    else begin m_wd++; if (m_wd >= TO) m_stale = 1; end
`endif
    cur = {seg, an};
    if (cur == m_last) m_run++; else m_run = 1;
    m_last = cur;
    low = ~an;
    if (m_run == STB && $countones(low) == 1) begin
      k = 0;
      for (int i = 0; i < ND; i++) if (low[i]) k = i;
      v = glyph_val(seg);
      m_sh[k] = (v < 0) ? 4'hF : 4'(v);
      m_er[k] = (v < 0);
      m_mk[k] = 1;
      full = 1;
      for (int i = 0; i < ND; i++) if (!m_mk[i]) full = 0;
      if (full != 0) m_pend = 1;
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge
  task automatic step(input logic [6:0] seg, input logic [3:0] an);
    bus.seg_in = seg;
    bus.an_in  = an;
    @(posedge clk);
    model_edge(seg, an);
    @(negedge clk);
    check("model_fv",    32'(bus.frame_valid), 32'(m_fv));
    check("model_bcd",   32'(bus.bcd_out),     32'(m_bcd));
    check("model_ferr",  32'(bus.frame_err),   32'(m_ferr));
    check("model_stale", 32'(bus.stale),       32'(m_stale));
  endtask

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  an;
    int          hold;
    logic [15:0] bcd;
    bit          err;
    bit          fv;
  } vec_t;

  vec_t tbl [15];
  bit   fv_seen;

  task automatic hold_digit(input logic [6:0] seg, input logic [3:0] an,
                            input int n);
    for (int c = 0; c < n; c++) begin
      step(seg, an);
      if (bus.frame_valid) fv_seen = 1;
    end
  endtask

  initial begin
    tbl[0]  = '{7'b0100100, 4'b1110, 6,  16'h0000, 0, 0};
    tbl[1]  = '{7'b1111001, 4'b1101, 6,  16'h0000, 0, 0};
    tbl[2]  = '{7'b1000000, 4'b1011, 6,  16'h0000, 0, 0};
    tbl[3]  = '{7'b0010000, 4'b0111, 6,  16'h9012, 0, 1};
    tbl[4]  = '{7'b0110000, 4'b1110, 2,  16'h9012, 0, 0};
    tbl[5]  = '{7'b0011001, 4'b1110, 6,  16'h9012, 0, 0};
    tbl[6]  = '{7'b1111001, 4'b1101, 6,  16'h9012, 0, 0};
    tbl[7]  = '{7'b1111111, 4'b1011, 6,  16'h9012, 0, 0};
    tbl[8]  = '{7'b0010000, 4'b0111, 6,  16'h9F14, 1, 1};
    tbl[9]  = '{7'b0100100, 4'b1100, 20, 16'h9F14, 1, 0};
    tbl[10] = '{7'b0100100, 4'b1111, 20, 16'h9F14, 1, 0};
    tbl[11] = '{7'b0000000, 4'b1110, 6,  16'h9F14, 1, 0};
    tbl[12] = '{7'b1111000, 4'b1101, 6,  16'h9F14, 1, 0};
    tbl[13] = '{7'b0000010, 4'b1011, 6,  16'h9F14, 1, 0};
    tbl[14] = '{7'b0010010, 4'b0111, 6,  16'h5678, 0, 1};

    bus.seg_in = 7'b1111111;
    bus.an_in  = 4'b1111;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_bcd",   32'(bus.bcd_out),     32'h0);
    check("reset_fv",    32'(bus.frame_valid), 32'h0);
    check("reset_ferr",  32'(bus.frame_err),   32'h0);
    check("reset_stale", 32'(bus.stale),       32'h0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      fv_seen = 0;
      hold_digit(tbl[i].seg, tbl[i].an, tbl[i].hold);
      check($sformatf("tbl%0d_fv", i),   32'(fv_seen),       32'(tbl[i].fv));
      check($sformatf("tbl%0d_bcd", i),  32'(bus.bcd_out),   32'(tbl[i].bcd));
      check($sformatf("tbl%0d_ferr", i), 32'(bus.frame_err), 32'(tbl[i].err));
    end

    // Mid-scan reset discards captured digits 0 and 1
    hold_digit(7'b0100100, 4'b1110, 5);
    hold_digit(7'b1111001, 4'b1101, 5);
    reset = 1'b0;
    #1;
    check("async_rst_bcd",  32'(bus.bcd_out),     32'h0);
    check("async_rst_fv",   32'(bus.frame_valid), 32'h0);
    check("async_rst_ferr", 32'(bus.frame_err),   32'h0);
    check("async_rst_stl",  32'(bus.stale),       32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    fv_seen = 0;
    hold_digit(7'b0110000, 4'b1101, 6);
    hold_digit(7'b0011001, 4'b1011, 6);
    hold_digit(7'b1111000, 4'b0111, 6);
    check("post_rst_nocommit", 32'(fv_seen), 32'h0);
    hold_digit(7'b1111001, 4'b1110, 6);
    check("post_rst_commit", 32'(fv_seen),     32'h1);
    check("post_rst_bcd",    32'(bus.bcd_out), 32'h7431);

`ifdef SEG_SCAN_DECODER_TIMEOUT_EN
    hold_digit(7'b1111111, 4'b1111, TO + 2);
    check("wd_stale_set", 32'(bus.stale), 32'h1);
    hold_digit(7'b0100100, 4'b1110, 6);
    hold_digit(7'b0100100, 4'b1101, 6);
    hold_digit(7'b0100100, 4'b1011, 6);
    bus.seg_in = 7'b0100100;
    bus.an_in  = 4'b0111;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      model_edge(7'b0100100, 4'b0111);
      @(negedge clk);
      if (bus.frame_valid)
        check("wd_stale_clr", 32'(bus.stale), 32'h0);
    end
    check("wd_bcd", 32'(bus.bcd_out), 32'h2222);
`endif

    for (int n = 0; n < 250; n++) begin
      logic [6:0] s;
      logic [3:0] a;
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 7) a = 4'b1111;
      else             a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) s = 7'($urandom_range(0, 127));
      else                           s = gly[$urandom_range(0, 9)];
      hold_digit(s, a, int'($urandom_range(1, 8)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
